// File: rtl/prefix_pkg.sv
// Shared types for the prefix adder output stage: default widths, the result
// record and the skid-buffer occupancy states.
package prefix_pkg;

    localparam int PREFIX_WIDTH = 32;
    localparam int PREFIX_TAG_W = 5;

    typedef struct packed {
        logic [PREFIX_WIDTH-1:0] sum;
        logic                    cout;
        logic                    ovf;
        logic                    zero;
        logic                    neg;
        logic [PREFIX_TAG_W-1:0] tag;
    } sum_result_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/prefix_sum_flags.sv
// Final sum formation and ALU status flags from the prefix network's
// propagate vector and group carries.
module prefix_sum_flags
    import prefix_pkg::*;
#(
    parameter int WIDTH = PREFIX_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] gc,
    input  logic             c0,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // Bit i sees the carry out of bit i-1; bit 0 sees the carry-in.
    assign sum  = p ^ {gc[WIDTH-2:0], c0};
    assign cout = gc[WIDTH-1];
    assign ovf  = gc[WIDTH-1] ^ gc[WIDTH-2];
    assign zero = ~|sum;
    assign neg  = sum[WIDTH-1];

endmodule

// File: rtl/prefix_sum_stage.sv
// Registered output stage of the prefix adder: result + flags into a
// 2-entry skid buffer (main register M, skid register S) with valid/ready.
//
// state | meaning
// EMPTY | nothing held, in_ready = 1
// ONE   | M holds the presented result, in_ready = 1
// TWO   | M presented, S holds the next result, in_ready = 0
module prefix_sum_stage
    import prefix_pkg::*;
#(
    parameter int WIDTH = PREFIX_WIDTH,
    parameter int TAG_W = PREFIX_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_p,
    input  logic [WIDTH-1:0] in_gc,
    input  logic             in_c0,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam res_t RES_ZERO = '0;

    res_t        in_res;
    res_t        m_q;
    res_t        s_q;
    skid_state_t state;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        sticky_q;
    logic        in_xfer;
    logic        out_xfer;

    prefix_sum_flags #(.WIDTH(WIDTH)) u_flags (
        .p    (in_p),
        .gc   (in_gc),
        .c0   (in_c0),
        .sum  (in_res.sum),
        .cout (in_res.cout),
        .ovf  (in_res.ovf),
        .zero (in_res.zero),
        .neg  (in_res.neg)
    );
    assign in_res.tag = in_tag;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            m_q         <= RES_ZERO;
            s_q         <= RES_ZERO;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        m_q         <= in_res;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_q <= in_res;
                    end else if (in_xfer) begin
                        s_q        <= in_res;
                        in_ready_q <= 1'b0;
                        state      <= TWO;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        m_q        <= s_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= EMPTY;
                end
            endcase
        end
    end

    // A setting transfer takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (out_xfer && m_q.ovf) begin
            sticky_q <= 1'b1;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sum    = m_q.sum;
    assign out_cout   = m_q.cout;
    assign out_ovf    = m_q.ovf;
    assign out_zero   = m_q.zero;
    assign out_neg    = m_q.neg;
    assign out_tag    = m_q.tag;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Directed and random checks of the prefix adder output stage against an
// a + b + c0 reference model.
module tb_prefix_sum_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        c0_d;
    logic [4:0]  tag_d;
    logic [31:0] in_p;
    logic [31:0] in_gc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;
    logic        out_neg;
    logic [4:0]  out_tag;
    logic        ovf_sticky;
    logic        ovf_clr;

    int checks   = 0;
    int failures = 0;

    // Ripple carry chain producing the prefix network's final group carries.
    function automatic logic [31:0] gc_of(input logic [31:0] a, input logic [31:0] b, input logic c0);
        logic [31:0] g;
        logic        c;
        c = c0;
        for (int i = 0; i < 32; i++) begin
            c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            g[i] = c;
        end
        return g;
    endfunction

    // Expected record {cout, ovf, zero, neg, tag, sum} from plain addition.
    function automatic logic [40:0] exp_rec(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic [4:0] tag);
        logic [32:0] full;
        logic        v;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c0};
        v    = (a[31] == b[31]) && (full[31] != a[31]);
        return {full[32], v, (full[31:0] == 32'd0), full[31], tag, full[31:0]};
    endfunction

    assign in_p  = a_d ^ b_d;
    assign in_gc = gc_of(a_d, b_d, c0_d);

    logic [40:0] dut_rec;
    assign dut_rec = {out_cout, out_ovf, out_zero, out_neg, out_tag, out_sum};

    prefix_sum_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p       (in_p),
        .in_gc      (in_gc),
        .in_c0      (c0_d),
        .in_tag     (tag_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_tag    (out_tag),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c0, input logic [4:0] tag);
        a_d      = a;
        b_d      = b;
        c0_d     = c0;
        tag_d    = tag;
        in_valid = 1'b1;
    endtask

    logic [40:0] q[$];
    logic [40:0] e;
    int          accepted;
    int          cyc;
    logic        hold;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        a_d = '0; b_d = '0; c0_d = 1'b0; tag_d = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_rec", dut_rec, 0);
        chk("rst_sticky", ovf_sticky, 0);
        @(negedge clk) rst_n = 1'b1;

        // Wrap to zero with carry-out.
        out_ready = 1'b1;
        @(posedge clk); #1 drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd7);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("wrap_valid", out_valid, 1);
        chk("wrap_rec", dut_rec, {1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0});
        @(posedge clk); #1;
        chk("wrap_drained", out_valid, 0);
        chk("wrap_sticky", ovf_sticky, 0);

        // Signed overflow into the sign bit.
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd9);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("ovf_rec", dut_rec, {1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h8000_0000});
        chk("ovf_sticky_pre", ovf_sticky, 0);
        @(posedge clk); #1;
        chk("ovf_sticky_post", ovf_sticky, 1);

        // Fill the skid buffer, then drain with no bubble.
        out_ready = 1'b0;
        drive(32'd100, 32'd1, 1'b0, 5'd1);
        @(posedge clk); #1;
        chk("skid_rdy1", in_ready, 1);
        drive(32'd200, 32'd2, 1'b1, 5'd2);
        @(posedge clk); #1;
        chk("skid_rdy2", in_ready, 0);
        drive(32'd300, 32'd3, 1'b0, 5'd3);
        @(posedge clk); #1;
        chk("skid_rdy3", in_ready, 0);
        chk("skid_hold1", dut_rec, exp_rec(32'd100, 32'd1, 1'b0, 5'd1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("skid_out2", dut_rec, exp_rec(32'd200, 32'd2, 1'b1, 5'd2));
        chk("skid_rdy4", in_ready, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("skid_valid3", out_valid, 1);
        chk("skid_out3", dut_rec, exp_rec(32'd300, 32'd3, 1'b0, 5'd3));
        @(posedge clk); #1;
        chk("skid_empty", out_valid, 0);

        // Clear alone, then clear colliding with an overflowing transfer.
        ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("clr_alone", ovf_sticky, 0);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd4);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("clr_rec", dut_rec, {1'b1, 1'b1, 1'b1, 1'b0, 5'd4, 32'h0});
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_set_wins", ovf_sticky, 1);
        @(posedge clk); #1 ovf_clr = 1'b0;
        chk("clr_next", ovf_sticky, 0);

        // Async reset while holding two results.
        out_ready = 1'b0;
        drive(32'd5, 32'd6, 1'b0, 5'd11);
        @(posedge clk); #1 drive(32'd7, 32'd8, 1'b0, 5'd12);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("two_rdy", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_rec", dut_rec, 0);
        chk("arst_rdy", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("arst_no_stale", out_valid, 0);
        end
        drive(32'd40, 32'd2, 1'b0, 5'd13);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("arst_fresh", dut_rec, exp_rec(32'd40, 32'd2, 1'b0, 5'd13));
        @(posedge clk); #1;

        // Random traffic with random backpressure.
        accepted = 0;
        cyc      = 0;
        hold     = 1'b0;
        while ((accepted < 1000 || q.size() != 0) && cyc < 20000) begin
            @(posedge clk); #1;
            if (!hold) begin
                if (accepted < 1000) begin
                    a_d      = $urandom;
                    b_d      = $urandom;
                    c0_d     = 1'($urandom_range(0, 1));
                    tag_d    = 5'($urandom_range(0, 31));
                    in_valid = ($urandom_range(0, 3) != 0);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_beat", dut_rec, e);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(exp_rec(a_d, b_d, c0_d, tag_d));
                accepted++;
                hold = 1'b0;
            end else begin
                hold = in_valid;
            end
            cyc++;
        end
        chk("rnd_accepted", accepted, 1000);
        chk("rnd_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
